lht: RTL and testbench

//  Local History Table: first stage of the local branch predictor, directly upstream of the PHT.
//  - Fetch path: indexes a 1024-entry table of 10-bit per-branch histories by fetch PC and

---
 rtl/lht_if.sv | 33 +++
 rtl/lht.sv | 92 +++++++++
 tb/tb_lht.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lht_if.sv
// Fetch/commit request and PHT-side response bundle of the local history table.
// The slave modport is the table itself; the master modport drives it (fetch/commit side).
interface lht_if #(
    parameter int PCWIDTH   = 64,
    parameter int HISTWIDTH = 10
);
    logic                 lht_fe_valid_i;
    logic [PCWIDTH-1:0]   lht_fe_pc_i;
    logic                 lht_fe_stall_i;
    logic                 lht_fe_flush_i;
    logic                 lht_cm_we_i;
    logic [PCWIDTH-1:0]   lht_cm_pc_i;
    logic                 lht_cm_brdir_i;
    logic                 pht_rd_valid_o;
    logic [HISTWIDTH-1:0] pht_rd_index_o;
    logic [HISTWIDTH-1:0] pht_wt_index_o;
    logic                 pht_cm_brdir_we_o;
    logic                 pht_cm_brdir_o;

    modport slave (
        input  lht_fe_valid_i, lht_fe_pc_i, lht_fe_stall_i, lht_fe_flush_i,
        input  lht_cm_we_i, lht_cm_pc_i, lht_cm_brdir_i,
        output pht_rd_valid_o, pht_rd_index_o, pht_wt_index_o,
        output pht_cm_brdir_we_o, pht_cm_brdir_o
    );

    modport master (
        output lht_fe_valid_i, lht_fe_pc_i, lht_fe_stall_i, lht_fe_flush_i,
        output lht_cm_we_i, lht_cm_pc_i, lht_cm_brdir_i,
        input  pht_rd_valid_o, pht_rd_index_o, pht_wt_index_o,
        input  pht_cm_brdir_we_o, pht_cm_brdir_o
    );
endinterface

// File: rtl/lht.sv
// Local history table: per-branch shift-register histories indexed by PC, feeding the PHT
// read index on fetch and the PHT update request on commit.
module lht #(
    parameter int LHTSIZE    = 1024,
    parameter int LOGLHTSIZE = 10,
    parameter int HISTWIDTH  = 10,
    parameter int PCWIDTH    = 64
) (
    input  logic clock,
    input  logic reset_n,
    lht_if.slave bus
);

    logic [HISTWIDTH-1:0]  hist_q [LHTSIZE];

    logic [LOGLHTSIZE-1:0] fe_idx;
    logic [LOGLHTSIZE-1:0] cm_idx;
    logic [HISTWIDTH-1:0]  cm_old;
    logic [HISTWIDTH-1:0]  cm_new;
    logic [HISTWIDTH-1:0]  fe_hist;

    logic                  rd_valid_q, rd_valid_d;
    logic [HISTWIDTH-1:0]  rd_index_q, rd_index_d;
    logic [HISTWIDTH-1:0]  wt_index_q, wt_index_d;
    logic                  brdir_q,    brdir_d;
    logic                  brdir_we_q, brdir_we_d;

    // pc[1:0] are dropped and upper PC bits alias deliberately: no tags.
    assign fe_idx = bus.lht_fe_pc_i[LOGLHTSIZE+1:2];
    assign cm_idx = bus.lht_cm_pc_i[LOGLHTSIZE+1:2];
    assign cm_old = hist_q[cm_idx];
    assign cm_new = {cm_old[HISTWIDTH-2:0], bus.lht_cm_brdir_i};

    // A fetch that collides with a same-cycle commit sees the post-shift history.
    assign fe_hist = (bus.lht_cm_we_i && (cm_idx == fe_idx)) ? cm_new : hist_q[fe_idx];

    always_comb begin
        rd_valid_d = rd_valid_q;
        rd_index_d = rd_index_q;
        wt_index_d = wt_index_q;
        brdir_d    = brdir_q;
        brdir_we_d = 1'b0;

        if (bus.lht_fe_flush_i) begin
            rd_valid_d = 1'b0;
        end else if (!bus.lht_fe_stall_i) begin
            rd_valid_d = bus.lht_fe_valid_i;
            if (bus.lht_fe_valid_i) begin
                rd_index_d = fe_hist;
            end
        end

        if (bus.lht_cm_we_i) begin
            wt_index_d = cm_old;
            brdir_d    = bus.lht_cm_brdir_i;
            brdir_we_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LHTSIZE; i++) begin
                hist_q[i] <= '0;
            end
        end else if (bus.lht_cm_we_i) begin
            hist_q[cm_idx] <= cm_new;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_index_q <= '0;
            wt_index_q <= '0;
            brdir_q    <= 1'b0;
            brdir_we_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_index_q <= rd_index_d;
            wt_index_q <= wt_index_d;
            brdir_q    <= brdir_d;
            brdir_we_q <= brdir_we_d;
        end
    end

    assign bus.pht_rd_valid_o    = rd_valid_q;
    assign bus.pht_rd_index_o    = rd_index_q;
    assign bus.pht_wt_index_o    = wt_index_q;
    assign bus.pht_cm_brdir_o    = brdir_q;
    assign bus.pht_cm_brdir_we_o = brdir_we_q;

endmodule

// File: tb/tb_lht.sv
// Directed bench for lht: inputs change on the falling edge, outputs are checked on the
// next falling edge, so each step spans exactly one rising edge.
module tb_lht;

    logic clock;
    logic reset_n;
    int   total  = 0;
    int   passed = 0;

    lht_if #(.PCWIDTH(64), .HISTWIDTH(10)) bus ();

    lht dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic fv, input logic [63:0] fpc, input logic st, input logic fl,
                         input logic cw, input logic [63:0] cpc, input logic cd);
        bus.lht_fe_valid_i = fv;
        bus.lht_fe_pc_i    = fpc;
        bus.lht_fe_stall_i = st;
        bus.lht_fe_flush_i = fl;
        bus.lht_cm_we_i    = cw;
        bus.lht_cm_pc_i    = cpc;
        bus.lht_cm_brdir_i = cd;
    endtask

    task automatic step(input logic fv, input logic [63:0] fpc, input logic st, input logic fl,
                        input logic cw, input logic [63:0] cpc, input logic cd);
        drive(fv, fpc, st, fl, cw, cpc, cd);
        @(negedge clock);
        $display("step fe=%0b/%h st=%0b fl=%0b cm=%0b/%h/%0b -> rv=%0b ri=%h wi=%h we=%0b d=%0b",
                 fv, fpc, st, fl, cw, cpc, cd, bus.pht_rd_valid_o, bus.pht_rd_index_o,
                 bus.pht_wt_index_o, bus.pht_cm_brdir_we_o, bus.pht_cm_brdir_o);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rv"}, 16'(bus.pht_rd_valid_o), 16'h0);
        chk({tag, ".ri"}, 16'(bus.pht_rd_index_o), 16'h0);
        chk({tag, ".wi"}, 16'(bus.pht_wt_index_o), 16'h0);
        chk({tag, ".we"}, 16'(bus.pht_cm_brdir_we_o), 16'h0);
        chk({tag, ".d"},  16'(bus.pht_cm_brdir_o), 16'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 64'h1000, 1'b0, 1'b0, 1'b1, 64'h1000, 1'b1);
        // T1: reset holds everything at zero even with active inputs
        repeat (3) @(negedge clock);
        chk_all_zero("t1_rst");
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        @(negedge clock);
        step(1, 64'h1000, 0, 0, 0, 0, 0);
        chk("t1_rv", 16'(bus.pht_rd_valid_o), 16'h1);
        chk("t1_ri", 16'(bus.pht_rd_index_o), 16'h000);

        // T2: shift 1,1,0 into entry of 0x1000, back-to-back
        step(0, 0, 0, 0, 1, 64'h1000, 1);
        chk("t2_rv0", 16'(bus.pht_rd_valid_o), 16'h0);
        chk("t2_wi0", 16'(bus.pht_wt_index_o), 16'h000);
        chk("t2_we0", 16'(bus.pht_cm_brdir_we_o), 16'h1);
        chk("t2_d0",  16'(bus.pht_cm_brdir_o), 16'h1);
        step(0, 0, 0, 0, 1, 64'h1000, 1);
        chk("t2_wi1", 16'(bus.pht_wt_index_o), 16'h001);
        step(0, 0, 0, 0, 1, 64'h1000, 0);
        chk("t2_wi2", 16'(bus.pht_wt_index_o), 16'h003);
        chk("t2_d2",  16'(bus.pht_cm_brdir_o), 16'h0);
        step(1, 64'h1000, 0, 0, 0, 0, 0);
        chk("t2_ri",  16'(bus.pht_rd_index_o), 16'h006);
        chk("t2_we",  16'(bus.pht_cm_brdir_we_o), 16'h0);
        chk("t2_wih", 16'(bus.pht_wt_index_o), 16'h003);

        // T3: 11 taken commits to 0x2004 saturate the width, then a not-taken one
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 64'h2004, 1);
        chk("t3_wi10", 16'(bus.pht_wt_index_o), 16'h1FF);
        step(0, 0, 0, 0, 1, 64'h2004, 1);
        chk("t3_wi11", 16'(bus.pht_wt_index_o), 16'h3FF);
        step(0, 0, 0, 0, 1, 64'h2004, 0);
        chk("t3_wi12", 16'(bus.pht_wt_index_o), 16'h3FF);
        chk("t3_d12",  16'(bus.pht_cm_brdir_o), 16'h0);
        step(1, 64'h2004, 0, 0, 0, 0, 0);
        chk("t3_ri",   16'(bus.pht_rd_index_o), 16'h3FE);

        // T4: bypass on entry 5 (pc 0x14) holding 0x001
        step(0, 0, 0, 0, 1, 64'h0014, 1);
        chk("t4_pre", 16'(bus.pht_wt_index_o), 16'h000);
        step(1, 64'h0014, 0, 0, 1, 64'h0014, 1);
        chk("t4_ri",  16'(bus.pht_rd_index_o), 16'h003);
        chk("t4_wi",  16'(bus.pht_wt_index_o), 16'h001);
        // aliasing: upper PC bits and pc[1:0] do not change the entry
        step(1, 64'hFFFF_0000_0000_1017, 0, 0, 0, 0, 0);
        chk("t4_alias", 16'(bus.pht_rd_index_o), 16'h003);
        // same-cycle fetch and commit on different entries stay independent
        step(1, 64'h2004, 0, 0, 1, 64'h0014, 0);
        chk("t4_ind_ri", 16'(bus.pht_rd_index_o), 16'h3FE);
        chk("t4_ind_wi", 16'(bus.pht_wt_index_o), 16'h003);

        // T5: fetch A (history 0), stall while presenting B, then flush
        step(1, 64'h0100, 0, 0, 0, 0, 0);
        chk("t5_a_rv", 16'(bus.pht_rd_valid_o), 16'h1);
        chk("t5_a_ri", 16'(bus.pht_rd_index_o), 16'h000);
        step(1, 64'h2004, 1, 0, 1, 64'h0200, 1);
        chk("t5_st_rv", 16'(bus.pht_rd_valid_o), 16'h1);
        chk("t5_st_ri", 16'(bus.pht_rd_index_o), 16'h000);
        chk("t5_st_we", 16'(bus.pht_cm_brdir_we_o), 16'h1);
        step(1, 64'h2004, 1, 1, 1, 64'h0200, 1);
        chk("t5_fl_rv", 16'(bus.pht_rd_valid_o), 16'h0);
        chk("t5_fl_wi", 16'(bus.pht_wt_index_o), 16'h001);
        step(1, 64'h0200, 0, 0, 0, 0, 0);
        chk("t5_cm_ri", 16'(bus.pht_rd_index_o), 16'h003);
        step(0, 64'h2004, 0, 0, 0, 0, 0);
        chk("t5_nv_rv", 16'(bus.pht_rd_valid_o), 16'h0);
        chk("t5_nv_ri", 16'(bus.pht_rd_index_o), 16'h003);

        // T6: asynchronous reset between edges right after a commit
        drive(1, 64'h2004, 0, 0, 1, 64'h1000, 1);
        @(posedge clock);
        #2;
        chk("t6_pre_we", 16'(bus.pht_cm_brdir_we_o), 16'h1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        step(1, 64'h1000, 0, 0, 0, 0, 0);
        chk("t6_ri0", 16'(bus.pht_rd_index_o), 16'h000);
        chk("t6_rv0", 16'(bus.pht_rd_valid_o), 16'h1);
        step(1, 64'h2004, 0, 0, 0, 0, 0);
        chk("t6_ri1", 16'(bus.pht_rd_index_o), 16'h000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
